// File: rtl/bsg_fsb_arb_pkg.sv
// Shared constants and helpers for the FSB node outbound arbiter.
package bsg_fsb_arb_pkg;

   localparam int ring_width_default_lp = 80;
   localparam int nodes_default_lp      = 3;

   localparam int node_nasti_lp  = 0;
   localparam int node_htif_lp   = 1;
   localparam int node_replay_lp = 2;

   // Circular index base+offset modulo n; callers keep offset within 0..n.
   function automatic int wrap_idx(input int base, input int offset, input int n);
      int sum_v;
      sum_v = base + offset;
      if (sum_v >= n) begin
         return sum_v - n;
      end else begin
         return sum_v;
      end
   endfunction

endpackage

// File: rtl/bsg_fsb_arb_two_fifo.sv
// Two-entry packet queue with occupancy count and registered full flag.
module bsg_fsb_arb_two_fifo
   import bsg_fsb_arb_pkg::*;
#(
   parameter int width_p = ring_width_default_lp
)
(
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic [1:0]         count_o,
   output logic               full_o
);

   logic [width_p-1:0] mem_r [2];
   logic               wptr_r;
   logic               rptr_r;
   logic [1:0]         count_r;
   logic [1:0]         count_s;
   logic               full_r;
   logic               push_s;
   logic               pop_s;

   assign push_s = push_i & ~full_r;
   assign pop_s  = pop_i & (count_r != 2'd0);

   // Occupancy after this cycle's push and pop.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + 2'd1;
         2'b01:   count_s = count_r - 2'd1;
         default: count_s = count_r;
      endcase
   end

   // Pointer, count and full-flag registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wptr_r  <= 1'b0;
         rptr_r  <= 1'b0;
         count_r <= 2'd0;
         full_r  <= 1'b0;
      end else begin
         if (push_s) begin
            wptr_r <= ~wptr_r;
         end
         if (pop_s) begin
            rptr_r <= ~rptr_r;
         end
         count_r <= count_s;
         full_r  <= (count_s == 2'd2);
      end
   end

   // Entry storage; contents only matter while counted as occupied.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wptr_r] <= data_i;
      end
   end

   assign data_o  = mem_r[rptr_r];
   assign count_o = count_r;
   assign full_o  = full_r;

endmodule

// File: rtl/bsg_fsb_node_out_arbiter.sv
// Round-robin, burst-limited arbiter merging FSB node outbound streams into one queued link.
// Define BSG_FSB_ARB_STATS_EN to add per-node grant counters and a stall counter.
module bsg_fsb_node_out_arbiter
   import bsg_fsb_arb_pkg::*;
#(
   parameter  int nodes_p      = nodes_default_lp,
   parameter  int ring_width_p = ring_width_default_lp,
   parameter  int max_burst_p  = 4,
   localparam int lg_nodes_lp  = $clog2(nodes_p)
)
(
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [nodes_p-1:0]      node_v_i,
   input  logic [ring_width_p-1:0] node_data_i [nodes_p],
   input  logic [nodes_p-1:0]      node_en_i,
   output logic [nodes_p-1:0]      node_yumi_o,
   output logic                    v_o,
   output logic [ring_width_p-1:0] data_o,
   input  logic                    ready_i,
   output logic [lg_nodes_lp-1:0]  grant_id_o
`ifdef BSG_FSB_ARB_STATS_EN
  ,output logic [31:0]             grant_count_o [nodes_p]
  ,output logic [31:0]             stall_count_o
`endif
);

   localparam int                      burst_w_lp    = $clog2(max_burst_p) + 1;
   localparam logic [burst_w_lp-1:0]   burst_last_lp = burst_w_lp'(max_burst_p - 1);
   localparam logic [lg_nodes_lp-1:0]  owner_init_lp = lg_nodes_lp'(nodes_p - 1);

   logic [nodes_p-1:0]     eligible_s;
   logic                   space_s;
   logic                   full_s;
   logic [1:0]             count_s;
   logic [nodes_p-1:0]     yumi_s;
   logic [lg_nodes_lp-1:0] winner_s;
   logic [lg_nodes_lp-1:0] cand_s;
   logic                   found_s;
   logic [lg_nodes_lp-1:0] owner_r;
   logic [lg_nodes_lp-1:0] owner_s;
   logic [burst_w_lp-1:0]  burst_cnt_r;
   logic [burst_w_lp-1:0]  burst_s;
   logic                   live_r;
   logic                   live_s;

   assign eligible_s = node_v_i & node_en_i;
   assign space_s    = ~full_s;

   // A burst only continues while the owner was granted without an idle gap,
   // so after reset or idle the scan starts just past the owner.
   always_comb begin
      yumi_s   = '0;
      winner_s = owner_r;
      cand_s   = owner_r;
      found_s  = 1'b0;
      owner_s  = owner_r;
      burst_s  = burst_cnt_r;
      live_s   = live_r;
      if (!reset_n_i || !space_s) begin
         yumi_s = '0;
      end else if (live_r && eligible_s[owner_r] && (burst_cnt_r < burst_last_lp)) begin
         yumi_s[owner_r] = 1'b1;
         burst_s         = burst_cnt_r + burst_w_lp'(1);
      end else begin
         burst_s = '0;
         for (int i = 1; i <= nodes_p; i++) begin
            cand_s = lg_nodes_lp'(wrap_idx(int'(owner_r), i, nodes_p));
            if (!found_s && eligible_s[cand_s]) begin
               found_s  = 1'b1;
               winner_s = cand_s;
            end else begin
               found_s = found_s;
            end
         end
         if (found_s) begin
            yumi_s[winner_s] = 1'b1;
            owner_s          = winner_s;
            live_s           = 1'b1;
         end else begin
            live_s = 1'b0;
         end
      end
   end

   // Grant ownership and burst tracking.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         owner_r     <= owner_init_lp;
         burst_cnt_r <= '0;
         live_r      <= 1'b0;
      end else begin
         owner_r     <= owner_s;
         burst_cnt_r <= burst_s;
         live_r      <= live_s;
      end
   end

   bsg_fsb_arb_two_fifo #(.width_p(ring_width_p)) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (|yumi_s),
      .data_i    (node_data_i[winner_s]),
      .pop_i     (v_o & ready_i),
      .data_o    (data_o),
      .count_o   (count_s),
      .full_o    (full_s)
   );

   assign node_yumi_o = yumi_s;
   assign v_o         = (count_s != 2'd0);
   assign grant_id_o  = owner_r;

`ifdef BSG_FSB_ARB_STATS_EN
   // Wrapping grant counters per node and a cycle count of back-pressured requests.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int n = 0; n < nodes_p; n++) begin
            grant_count_o[n] <= 32'd0;
         end
         stall_count_o <= 32'd0;
      end else begin
         for (int n = 0; n < nodes_p; n++) begin
            if (yumi_s[n]) begin
               grant_count_o[n] <= grant_count_o[n] + 32'd1;
            end
         end
         if ((|eligible_s) && !space_s) begin
            stall_count_o <= stall_count_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bsg_fsb_node_out_arbiter.sv
// Scoreboard bench: packets encode {node, sequence}; expected order is hand-computed per scenario.
module tb_bsg_fsb_node_out_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  node_v;
   logic [2:0]  node_en;
   logic [2:0]  node_yumi;
   logic [79:0] node_data [3];
   logic        v;
   logic [79:0] data;
   logic        ready;
   logic [1:0]  grant_id;

   int remain [3];
   int seq    [3];
   int grants [3];

   logic [2:0]  yumi_smp;
   logic        v_smp;
   logic [79:0] data_smp;
   logic [1:0]  gid_smp;

   logic [79:0] exp_pkt_q [$];
   string       chk_name_q [$];
   logic [95:0] chk_act_q [$];
   logic [95:0] chk_exp_q [$];

   int checks   = 0;
   int failures = 0;
   int yc;
   int g1;

   always #5 clk = ~clk;

   bsg_fsb_node_out_arbiter #(.nodes_p(3), .ring_width_p(80), .max_burst_p(4)) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .node_v_i    (node_v),
      .node_data_i (node_data),
      .node_en_i   (node_en),
      .node_yumi_o (node_yumi),
      .v_o         (v),
      .data_o      (data),
      .ready_i     (ready),
      .grant_id_o  (grant_id)
   );

   function automatic logic [79:0] pkt(input int n, input int s);
      logic [79:0] p;
      p        = '0;
      p[23:16] = 8'(n);
      p[15:0]  = 16'(s);
      return p;
   endfunction

   always_comb begin
      for (int n = 0; n < 3; n++) begin
         node_v[n]    = (remain[n] != 0);
         node_data[n] = pkt(n, seq[n]);
      end
   end

   task automatic exp_pkt(input int n, input int s);
      exp_pkt_q.push_back(pkt(n, s));
   endtask

   task automatic expect_eq(input string name, input logic [95:0] act, input logic [95:0] exp);
      chk_name_q.push_back(name);
      chk_act_q.push_back(act);
      chk_exp_q.push_back(exp);
   endtask

   // One cycle: sample outputs mid-cycle, then let each source consume on yumi.
   task automatic tick();
      @(negedge clk);
      yumi_smp = node_yumi;
      v_smp    = v;
      data_smp = data;
      gid_smp  = grant_id;
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) begin
         if (yumi_smp[n]) begin
            seq[n]    = seq[n] + 1;
            grants[n] = grants[n] + 1;
            if (remain[n] > 0) remain[n] = remain[n] - 1;
         end
      end
   endtask

   task automatic drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick();
         if (exp_pkt_q.size() == 0 && !v_smp) done = 1'b1;
      end
      expect_eq({name, "_drain_pending"}, 96'(exp_pkt_q.size()), 96'd0);
   endtask

   // Monitor: scoreboard pops on each accepted output, protocol checks, queued comparisons.
   always @(negedge clk) begin : monitor
      int          c;
      int          f;
      logic [79:0] e;
      string       nm;
      logic [95:0] a;
      logic [95:0] x;
      c = 0;
      f = 0;
      if (reset_n) begin
         if (v && ready) begin
            c = c + 1;
            if (exp_pkt_q.size() == 0) begin
               f = f + 1;
               $display("FAIL unexpected_pkt actual=%h required=none", data);
            end else begin
               e = exp_pkt_q.pop_front();
               if (data !== e) begin
                  f = f + 1;
                  $display("FAIL pkt_order actual=%h required=%h", data, e);
               end
            end
         end
         c = c + 1;
         if (!$onehot0(node_yumi) || ((node_yumi & ~(node_v & node_en)) != 3'b000)) begin
            f = f + 1;
            $display("FAIL yumi_legal actual=%b required=onehot0_within=%b", node_yumi, node_v & node_en);
         end
      end else begin
         c = c + 1;
         if (node_yumi !== 3'b000) begin
            f = f + 1;
            $display("FAIL reset_no_yumi actual=%b required=000", node_yumi);
         end
      end
      while (chk_name_q.size() != 0) begin
         nm = chk_name_q.pop_front();
         a  = chk_act_q.pop_front();
         x  = chk_exp_q.pop_front();
         c  = c + 1;
         if (a !== x) begin
            f = f + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, a, x);
         end
      end
      checks   <= checks + c;
      failures <= failures + f;
   end

   initial begin
      reset_n = 1'b0;
      ready   = 1'b1;
      node_en = 3'b111;
      for (int n = 0; n < 3; n++) begin
         remain[n] = 0;
         seq[n]    = 0;
         grants[n] = 0;
      end

      // Reset state.
      tick();
      tick();
      expect_eq("rst_v", 96'(v_smp), 96'd0);
      expect_eq("rst_grant_id", 96'(gid_smp), 96'd2);
      reset_n = 1'b1;
      tick();
      expect_eq("idle_v", 96'(v_smp), 96'd0);
      expect_eq("idle_yumi", 96'(yumi_smp), 96'd0);
      expect_eq("idle_grant_id", 96'(gid_smp), 96'd2);

      // All nodes valid: bursts of 4 in round-robin order, one packet per cycle.
      for (int n = 0; n < 3; n++) remain[n] = 5;
      for (int n = 0; n < 3; n++) for (int s = 0; s < 4; s++) exp_pkt(n, s);
      for (int n = 0; n < 3; n++) exp_pkt(n, 4);
      yc = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (yumi_smp != 3'b000) yc = yc + 1;
         if (i == 0) begin
            expect_eq("t1_first_yumi", 96'(yumi_smp), 96'd1);
            expect_eq("t1_v_before_push", 96'(v_smp), 96'd0);
         end else if (i == 1) begin
            expect_eq("t1_v_latency", 96'(v_smp), 96'd1);
         end
      end
      expect_eq("t1_throughput", 96'(yc), 96'd15);
      drain("t1");

      // Lone requester keeps the grant indefinitely.
      remain[1] = 10;
      for (int s = 5; s < 15; s++) exp_pkt(1, s);
      yc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (yumi_smp == 3'b010) yc = yc + 1;
      end
      expect_eq("t2_lone_no_gaps", 96'(yc), 96'd10);
      drain("t2");

      // Back-pressure: two yumis fill the queue, head holds, push resumes after first pop.
      ready     = 1'b0;
      remain[0] = 4;
      for (int s = 5; s < 9; s++) exp_pkt(0, s);
      yc = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (yumi_smp != 3'b000) yc = yc + 1;
         if (i >= 2) expect_eq("t3_head_stable", 96'(data_smp), 96'(pkt(0, 5)));
      end
      expect_eq("t3_two_yumis", 96'(yc), 96'd2);
      expect_eq("t3_v_held", 96'(v_smp), 96'd1);
      ready = 1'b1;
      tick();
      expect_eq("t3_no_push_when_full", 96'(yumi_smp), 96'd0);
      tick();
      expect_eq("t3_push_resumes", 96'(yumi_smp), 96'd1);
      drain("t3");

      // Node 1 disabled: bursts alternate between nodes 2 and 0.
      node_en   = 3'b101;
      remain[0] = 5;
      remain[1] = 2;
      remain[2] = 5;
      g1        = grants[1];
      for (int s = 5; s < 9; s++) exp_pkt(2, s);
      for (int s = 9; s < 13; s++) exp_pkt(0, s);
      exp_pkt(2, 9);
      exp_pkt(0, 13);
      drain("t4");
      expect_eq("t4_node1_never", 96'(grants[1] - g1), 96'd0);
      remain[1] = 0;
      node_en   = 3'b111;

      // Enable dropped mid-burst: grant moves to node 1 in the same cycle.
      remain[0] = 6;
      for (int s = 14; s < 17; s++) exp_pkt(0, s);
      for (int s = 15; s < 18; s++) exp_pkt(1, s);
      for (int s = 17; s < 20; s++) exp_pkt(0, s);
      tick();
      tick();
      tick();
      expect_eq("t5_burst_node0", 96'(yumi_smp), 96'd1);
      node_en   = 3'b110;
      remain[1] = 3;
      tick();
      expect_eq("t5_switch_same_cycle", 96'(yumi_smp), 96'd2);
      tick();
      tick();
      node_en = 3'b111;
      drain("t5");

      // Reset with a full queue discards it; node 0 wins first afterwards.
      ready     = 1'b0;
      remain[0] = 4;
      tick();
      tick();
      tick();
      expect_eq("t6_full_before_reset", 96'(v_smp), 96'd1);
      reset_n   = 1'b0;
      remain[1] = 2;
      remain[2] = 2;
      tick();
      expect_eq("t6_reset_cycle_yumi", 96'(yumi_smp), 96'd0);
      tick();
      expect_eq("t6_v_cleared", 96'(v_smp), 96'd0);
      expect_eq("t6_yumi_cleared", 96'(yumi_smp), 96'd0);
      expect_eq("t6_grant_id", 96'(gid_smp), 96'd2);
      reset_n = 1'b1;
      ready   = 1'b1;
      exp_pkt(0, 22);
      exp_pkt(0, 23);
      exp_pkt(1, 18);
      exp_pkt(1, 19);
      exp_pkt(2, 10);
      exp_pkt(2, 11);
      tick();
      expect_eq("t6_first_grant_node0", 96'(yumi_smp), 96'd1);
      drain("t6");

      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
